// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter and its helper blocks:
// FSM state encoding and default sizing.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } meter_state_e;

  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_period_meter_if.sv
// Result/control bundle of the clock period meter. The meter drives the
// measurement results; the consumer (firmware bridge, checker) drives enable.
interface clk_period_meter_if
  import clk_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             enable;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             timeout;

  modport master (
    input  enable,
    output period,
    output high_time,
    output valid,
    output timeout
  );

  modport slave (
    output enable,
    input  period,
    input  high_time,
    input  valid,
    input  timeout
  );

endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// Synchronizer for an asynchronous clock-like input plus a registered
// rising-edge detector. SYNC_STAGES must be at least 2. The rise output is a
// flop whose value equals s_in & ~s_in(previous cycle), so it is high in the
// first cycle in which s_in reads 1.
module sync_edge_det
  import clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic s_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   rise_q;
  logic                   rise_d;

  // Shift the input through the chain; look one stage ahead so the edge flag
  // lines up with the first high cycle of s_in.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    rise_d = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign s_in = sync_q[SYNC_STAGES-1];
  assign rise = rise_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of clk_in in clk cycles. Results update with
// a one-cycle valid pulse on every rising edge of clk_in once a full period
// has been observed; a sticky timeout flags a missing edge.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_in,
  clk_period_meter_if.master bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             s_in;
  logic             rise;

  meter_state_e     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (clk_in),
    .s_in (s_in),
    .rise (rise)
  );

  // Next-state logic: counters restart at 1 on each edge because the edge
  // cycle itself belongs to the new period; an edge in the same cycle as a
  // full counter still completes the measurement instead of timing out.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!bus.enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d     = '0;
          hcnt_d    = '0;
          timeout_d = 1'b0;
          state_d   = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d    = cnt_q;
            high_time_d = hcnt_q;
            valid_d     = 1'b1;
            cnt_d       = CNT_ONE;
            hcnt_d      = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            hcnt_d    = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (s_in) begin
              hcnt_d = hcnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_time_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;

endmodule
